// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for vga_timing_gen.
// The defaults describe the 640x480@60 display driven from a 100 MHz clock.
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV  = 4;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_CW       = 10;

  localparam int unsigned FRAME_CNT_W  = 16;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Pin level for a sync pulse given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic active, input sync_pol_e pol);
    logic lvl;
    lvl = (pol == SYNC_ACTIVE_HIGH);
    return active ? lvl : ~lvl;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel-rate enable: one registered pulse every CLK_DIV clocks while en is high.
// With CLK_DIV == 1 the pulse is held high for as long as en stays high.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pixTick
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  always_comb begin
    div_d = '0;
    if (en && (div_q != DIV_LAST)) begin
      div_d = div_q + 1'b1;
    end
  end

  // pixTick is registered from the next divider value so it is high exactly
  // while the divider sits at its last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      pixTick <= 1'b0;
    end else begin
      div_q   <= div_d;
      pixTick <= en && (div_d == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator (sync, data enable, position, strobes).
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frameCount output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CW       = VGA_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pixTick,
  output logic          hSync,
  output logic          vSync,
  output logic          dataEnable,
  output logic [CW-1:0] xPosition,
  output logic [CW-1:0] yPosition,
  output logic          lineStart,
  output logic          frameStart
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frameCount
`endif
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam sync_pol_e POL       = (SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
  localparam logic      SYNC_IDLE = sync_level(1'b0, POL);

  logic          wrap_line;
  logic          wrap_frame;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;
  logic          hs_next;
  logic          vs_next;
  logic          de_next;
  logic          ls_next;
  logic          fs_next;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .pixTick(pixTick)
  );

  assign wrap_line  = (xPosition == H_LAST);
  assign wrap_frame = wrap_line && (yPosition == V_LAST);

  always_comb begin
    x_next = xPosition + 1'b1;
    y_next = yPosition;
    if (wrap_line) begin
      x_next = '0;
      if (yPosition == V_LAST) begin
        y_next = '0;
      end else begin
        y_next = yPosition + 1'b1;
      end
    end
  end

  // Decode from the upcoming position so every registered output describes
  // the same pixel that xPosition/yPosition will show.
  always_comb begin
    hs_next = sync_level((x_next >= HS_FIRST) && (x_next <= HS_LAST), POL);
    vs_next = sync_level((y_next >= VS_FIRST) && (y_next <= VS_LAST), POL);
    de_next = (x_next < H_VIS) && (y_next < V_VIS);
    ls_next = (x_next == '0);
    fs_next = (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xPosition  <= '0;
      yPosition  <= '0;
      hSync      <= SYNC_IDLE;
      vSync      <= SYNC_IDLE;
      dataEnable <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (!en) begin
      xPosition  <= '0;
      yPosition  <= '0;
      hSync      <= SYNC_IDLE;
      vSync      <= SYNC_IDLE;
      dataEnable <= 1'b0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else if (pixTick) begin
      xPosition  <= x_next;
      yPosition  <= y_next;
      hSync      <= hs_next;
      vSync      <= vs_next;
      dataEnable <= de_next;
      lineStart  <= ls_next;
      frameStart <= fs_next;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (!en) begin
      frame_cnt <= '0;
    end else if (pixTick && wrap_frame) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign frameCount = frame_cnt;
`else
  logic unused_wrap;
  assign unused_wrap = wrap_frame;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny CLK_DIV=1, active-high instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic en_a, en_b;

  logic       pixTick_a, hSync_a, vSync_a, dataEnable_a, lineStart_a, frameStart_a;
  logic [9:0] xPosition_a, yPosition_a;
  logic       pixTick_b, hSync_b, vSync_b, dataEnable_b, lineStart_b, frameStart_b;
  logic [9:0] xPosition_b, yPosition_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .en(en_a), .pixTick(pixTick_a),
    .hSync(hSync_a), .vSync(vSync_a), .dataEnable(dataEnable_a),
    .xPosition(xPosition_a), .yPosition(yPosition_a),
    .lineStart(lineStart_a), .frameStart(frameStart_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frameCount(fc_a)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .CW(10)
  ) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .pixTick(pixTick_b),
    .hSync(hSync_b), .vSync(vSync_b), .dataEnable(dataEnable_b),
    .xPosition(xPosition_b), .yPosition(yPosition_b),
    .lineStart(lineStart_b), .frameStart(frameStart_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frameCount(fc_b)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // statistics gathered by the monitors during the first runs
  bit          a_run1 = 1'b0, b_run1 = 1'b0, a_have_last = 1'b0;
  int unsigned a_last_cyc = 0, a_gap_min = 32'hFFFF_FFFF, a_gap_max = 0;
  int unsigned a_l1_ticks = 0, a_l1_hs = 0, a_l1_de = 0;
  int unsigned a_hs_xmin = 32'hFFFF_FFFF, a_hs_xmax = 0;
  int unsigned b_fs = 0, b_ls = 0, b_vs = 0, b_fs_without_ls = 0;
  int unsigned b_hs_xmin = 32'hFFFF_FFFF, b_hs_xmax = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned k,
                                 input int unsigned ha, input int unsigned hf,
                                 input int unsigned hsw, input int unsigned hb,
                                 input int unsigned va, input int unsigned vf,
                                 input int unsigned vsw, input int unsigned vb,
                                 input bit pol);
    int unsigned ht, vt, x, y;
    exp_t e;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    x = k % ht;
    y = (k / ht) % vt;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = ((x >= ha + hf) && (x < ha + hf + hsw)) ? pol : !pol;
    e.vs = ((y >= va + vf) && (y < va + vf + vsw)) ? pol : !pol;
    e.de = (x < ha) && (y < va);
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    e.fc = 16'(k / (ht * vt));
    return e;
  endfunction

  function automatic logic [24:0] pack_exp(input exp_t e);
    return {e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs};
  endfunction

  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (pixTick_a) begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check($sformatf("a_tick x=%0d y=%0d", e.x, e.y),
                {xPosition_a, yPosition_a, hSync_a, vSync_a, dataEnable_a, lineStart_a, frameStart_a},
                pack_exp(e));
`ifdef VGA_TIMING_FRAME_CNT_EN
          check($sformatf("a_fc x=%0d y=%0d", e.x, e.y), fc_a, e.fc);
`endif
          if (a_run1) begin
            if (a_have_last) begin
              if (cyc - a_last_cyc < a_gap_min) a_gap_min = cyc - a_last_cyc;
              if (cyc - a_last_cyc > a_gap_max) a_gap_max = cyc - a_last_cyc;
            end
            a_last_cyc  = cyc;
            a_have_last = 1'b1;
            if (yPosition_a == 10'd1) begin
              a_l1_ticks++;
              if (dataEnable_a) a_l1_de++;
              if (!hSync_a) begin
                a_l1_hs++;
                if (xPosition_a < a_hs_xmin) a_hs_xmin = xPosition_a;
                if (xPosition_a > a_hs_xmax) a_hs_xmax = xPosition_a;
              end
            end
          end
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (pixTick_b) begin
        @(posedge clk);
        #1;
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check($sformatf("b_tick x=%0d y=%0d", e.x, e.y),
                {xPosition_b, yPosition_b, hSync_b, vSync_b, dataEnable_b, lineStart_b, frameStart_b},
                pack_exp(e));
`ifdef VGA_TIMING_FRAME_CNT_EN
          check($sformatf("b_fc x=%0d y=%0d", e.x, e.y), fc_b, e.fc);
`endif
          if (b_run1) begin
            if (frameStart_b) b_fs++;
            if (frameStart_b && !lineStart_b) b_fs_without_ls++;
            if (lineStart_b) b_ls++;
            if (vSync_b) b_vs++;
            if (hSync_b) begin
              if (xPosition_b < b_hs_xmin) b_hs_xmin = xPosition_b;
              if (xPosition_b > b_hs_xmax) b_hs_xmax = xPosition_b;
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    check({name, "_drain_a"}, qa.size(), 0);
    check({name, "_drain_b"}, qb.size(), 0);
  endtask

  task automatic check_cleared_a(input string name);
    check({name, "_x"}, xPosition_a, 0);
    check({name, "_y"}, yPosition_a, 0);
    check({name, "_tick"}, pixTick_a, 0);
    check({name, "_hs"}, hSync_a, 1);
    check({name, "_vs"}, vSync_a, 1);
    check({name, "_de"}, dataEnable_a, 0);
    check({name, "_ls"}, lineStart_a, 0);
    check({name, "_fs"}, frameStart_a, 0);
  endtask

  initial begin : stim
    reset = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared_a("rst_a");
    check("rst_b_hs", hSync_b, 0);
    check("rst_b_vs", vSync_b, 0);
    check("rst_b_tick", pixTick_b, 0);

    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared_a("idle_a");
    check("idle_b_tick", pixTick_b, 0);

    // run 1: A to (700,2), B through three full frames
    for (int unsigned k = 1; k <= 2300; k++) qa.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    for (int unsigned k = 1; k <= 299; k++)  qb.push_back(model(k, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
    a_run1 = 1'b1;
    b_run1 = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("start1_x_before", xPosition_a, 0);
    @(posedge clk);
    #1;
    check("start1_x_after4", xPosition_a, 1);
    wait_drain("run1", 12000);
    a_run1 = 1'b0;
    b_run1 = 1'b0;

    check("a_gap_min", a_gap_min, 4);
    check("a_gap_max", a_gap_max, 4);
    check("a_line_ticks", a_l1_ticks, 800);
    check("a_hs_ticks", a_l1_hs, 96);
    check("a_hs_xmin", a_hs_xmin, 656);
    check("a_hs_xmax", a_hs_xmax, 751);
    check("a_de_ticks", a_l1_de, 640);
    check("b_frame_starts", b_fs, 3);
    check("b_fs_without_ls", b_fs_without_ls, 0);
    check("b_line_starts", b_ls, 21);
    check("b_vs_ticks", b_vs, 42);
    check("b_hs_xmin", b_hs_xmin, 10);
    check("b_hs_xmax", b_hs_xmax, 11);

    // drop en on A mid-line, then re-raise
    check("drop_at_x", xPosition_a, 700);
    check("drop_at_y", yPosition_a, 2);
    en_a = 1'b0;
    @(posedge clk);
    #1;
    check_cleared_a("en_low_a");
    repeat (5) @(negedge clk);
    for (int unsigned k = 1; k <= 900; k++) qa.push_back(model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    en_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("start2_x_before", xPosition_a, 0);
    @(posedge clk);
    #1;
    check("start2_x_after4", xPosition_a, 1);
    wait_drain("run2", 5000);

`ifdef VGA_TIMING_FRAME_CNT_EN
    @(negedge clk);
    force dut_b.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut_b.frame_cnt;
    #1;
    check("fc_forced", fc_b, 16'hFFFF);
    for (int unsigned i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (frameStart_b) break;
    end
    check("fc_wrap_seen", frameStart_b, 1);
    check("fc_wrap_value", fc_b, 0);
`endif

    @(negedge clk) en_b = 1'b0;
    @(posedge clk);
    #1;
    check("en_low_b_x", xPosition_b, 0);
    check("en_low_b_hs", hSync_b, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("en_low_b_fc", fc_b, 0);
`endif

    // asynchronous reset in the middle of a clock period
    @(posedge clk);
    #2;
    check("pre_async_running", (xPosition_a != 0), 1);
    reset = 1'b0;
    #1;
    check_cleared_a("async_rst_a");
    check("async_rst_b_hs", hSync_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
